// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and LSU state constants.
package rv32i_pkg;

  localparam logic [2:0] F3_BYTE  = 3'd0;
  localparam logic [2:0] F3_HALF  = 3'd1;
  localparam logic [2:0] F3_WORD  = 3'd2;
  localparam logic [2:0] F3_UBYTE = 3'd4;
  localparam logic [2:0] F3_UHALF = 3'd5;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE  = 2'd0;
  localparam lsu_state_t ST_ISSUE = 2'd1;
  localparam lsu_state_t ST_WAIT  = 2'd2;
  localparam lsu_state_t ST_RESP  = 2'd3;

  // Encoding and alignment faults; the address-range check lives with MEM_AW in the top.
  function automatic logic align_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic f;
    case (f3)
      F3_BYTE:  f = 1'b0;
      F3_HALF:  f = off[0];
      F3_WORD:  f = |off;
      F3_UBYTE: f = we;
      F3_UHALF: f = we | off[0];
      default:  f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the addressed lane down and sign/zero extends it.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;

  assign w_lane = i_rdata >> {i_offset, 3'b000};

  // Extension selected by access width and signedness.
  always_comb begin
    o_data = w_lane;
    case (i_func3)
      F3_BYTE:  o_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_HALF:  o_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_UBYTE: o_data = {24'd0, w_lane[7:0]};
      F3_UHALF: o_data = {16'd0, w_lane[15:0]};
      default:  o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory requester: one load/store per handshake, word RAM with byte enables.
// Optional LSU_PERF_EN adds load/store/fault response counters.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef LSU_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_faults
`endif
);

  lsu_state_t        r_state;
  logic              r_req_ready;
  logic              r_we;
  logic [2:0]        r_func3;
  logic [1:0]        r_off;
  logic              r_resp_valid;
  logic              r_resp_fault;
  logic [31:0]       r_resp_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_fault;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  assign w_fault = align_fault(req_we, req_func3, req_addr[1:0]) | (|(req_addr >> (MEM_AW + 2)));

  // Store lane enables and replicated data; loads read the whole word.
  always_comb begin
    w_be    = 4'hF;
    w_wdata = req_wdata;
    if (req_we) begin
      case (req_func3)
        F3_BYTE: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        F3_HALF: begin
          w_be    = 4'b0011 << req_addr[1:0];
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'hF;
          w_wdata = req_wdata;
        end
      endcase
    end else begin
      w_be    = 4'hF;
      w_wdata = req_wdata;
    end
  end

  lsu_load_align u_align (
    .i_rdata  (mem_rdata),
    .i_func3  (r_func3),
    .i_offset (r_off),
    .o_data   (w_load_data)
  );

  // Transaction FSM; a reset abandons any in-flight access, so late rvalids find IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_func3      <= 3'd0;
      r_off        <= 2'd0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_func3     <= req_func3;
            r_off       <= req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state     <= ST_ISSUE;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_be    <= w_be;
              r_mem_addr  <= req_addr[MEM_AW+1:2];
              r_mem_wdata <= w_wdata;
            end
          end
        end
        ST_ISSUE: begin
          // A same-cycle rvalid is not a response; the RAM answers after the grant.
          if (mem_gnt) begin
            r_state   <= ST_WAIT;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= r_we ? 32'd0 : w_load_data;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_mem_req    <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

`ifdef LSU_PERF_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_faults;

  // One count per response pulse, classified by fault first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_loads  <= 32'd0;
      r_perf_stores <= 32'd0;
      r_perf_faults <= 32'd0;
    end else if (r_resp_valid) begin
      if (r_resp_fault) begin
        r_perf_faults <= r_perf_faults + 32'd1;
      end else if (r_we) begin
        r_perf_stores <= r_perf_stores + 32'd1;
      end else begin
        r_perf_loads <= r_perf_loads + 32'd1;
      end
    end
  end

  assign perf_loads  = r_perf_loads;
  assign perf_stores = r_perf_stores;
  assign perf_faults = r_perf_faults;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default build, MEM_AW=6).
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.MEM_AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; RAM handshake is driven cycle by cycle.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
                     input int gnt_wait, input bit dup_rv, input logic exp_fault,
                     input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                     input logic [5:0] exp_maddr, input logic [31:0] exp_mwdata);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_wdata = 32'h0;
    chk({tag, ".ready_low"}, 32'(req_ready), 32'd0);
    if (!exp_fault) begin
      chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
      chk({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(exp_maddr));
      if (we) chk({tag, ".mem_wdata"}, mem_wdata, exp_mwdata);
      for (int i = 0; i < gnt_wait; i++) begin
        tick();
        chk({tag, ".hold_req"}, 32'(mem_req), 32'd1);
        chk({tag, ".hold_addr"}, 32'(mem_addr), 32'(exp_maddr));
        chk({tag, ".hold_be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".hold_resp"}, 32'(resp_valid), 32'd0);
      end
      mem_gnt = 1'b1;
      if (dup_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      tick();
      mem_gnt = 1'b0;
      chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
      chk({tag, ".no_early_resp"}, 32'(resp_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end else begin
      chk({tag, ".no_mem_req"}, 32'(mem_req), 32'd0);
    end
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_fault"}, 32'(resp_fault), 32'(exp_fault));
    chk({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    tick();
    chk({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    chk({tag, ".mem_idle"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_func3  = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_fault", 32'(resp_fault), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // Loads with alignment and extension
    txn("lw08",  1'b0, 3'd2, 32'h08, 32'h0, 32'h1F1E1D1C, 0, 1'b0, 1'b0, 32'h1F1E1D1C, 4'hF, 6'd2, 32'h0);
    txn("lb0b",  1'b0, 3'd0, 32'h0B, 32'h0, 32'h9C1E1D1C, 0, 1'b0, 1'b0, 32'hFFFFFF9C, 4'hF, 6'd2, 32'h0);
    txn("lbu0b", 1'b0, 3'd4, 32'h0B, 32'h0, 32'h9C1E1D1C, 0, 1'b0, 1'b0, 32'h0000009C, 4'hF, 6'd2, 32'h0);
    txn("lhu0a", 1'b0, 3'd5, 32'h0A, 32'h0, 32'h9C1E1D1C, 0, 1'b0, 1'b0, 32'h00009C1E, 4'hF, 6'd2, 32'h0);
    txn("lh0a",  1'b0, 3'd1, 32'h0A, 32'h0, 32'h9C1E1D1C, 0, 1'b0, 1'b0, 32'hFFFF9C1E, 4'hF, 6'd2, 32'h0);
    txn("lb01",  1'b0, 3'd0, 32'h01, 32'h0, 32'h00007F00, 0, 1'b0, 1'b0, 32'h0000007F, 4'hF, 6'd0, 32'h0);
    txn("lwtop", 1'b0, 3'd2, 32'hFC, 32'h0, 32'hA5A5_5A5A, 0, 1'b0, 1'b0, 32'hA5A5_5A5A, 4'hF, 6'd63, 32'h0);

    // Stores: lane enables and replicated data
    txn("sh06", 1'b1, 3'd1, 32'h06, 32'h0000BEEF, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'b1100, 6'd1, 32'hBEEFBEEF);
    txn("sb05", 1'b1, 3'd0, 32'h05, 32'h12345677, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'b0010, 6'd1, 32'h77777777);
    txn("sw10", 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'hF, 6'd4, 32'hCAFEF00D);

    // Faults: misaligned, out of range, illegal func3, unsigned store
    txn("lw05f",  1'b0, 3'd2, 32'h05,  32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 6'd0, 32'h0);
    txn("sw100f", 1'b1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 6'd0, 32'h0);
    txn("lh03f",  1'b0, 3'd1, 32'h03,  32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 6'd0, 32'h0);
    txn("f3_3f",  1'b0, 3'd3, 32'h00,  32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 6'd0, 32'h0);
    txn("sbuf",   1'b1, 3'd4, 32'h00,  32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0, 6'd0, 32'h0);

    // Grant withheld 5 cycles; grant with simultaneous rvalid
    txn("gntwait", 1'b0, 3'd2, 32'h10, 32'h0, 32'h01234567, 5, 1'b0, 1'b0, 32'h01234567, 4'hF, 6'd4, 32'h0);
    txn("gntrv",   1'b0, 3'd2, 32'h14, 32'h0, 32'h89ABCDEF, 0, 1'b1, 1'b0, 32'h89ABCDEF, 4'hF, 6'd5, 32'h0);

    // Reset in WAIT, then a stale rvalid
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_func3 = 3'd2;
    req_addr  = 32'h20;
    tick();
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.ready", 32'(req_ready), 32'd1);
    chk("midrst.mem_req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("stale.resp_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("stale.resp_valid2", 32'(resp_valid), 32'd0);
    chk("stale.ready", 32'(req_ready), 32'd1);
    txn("postrst", 1'b0, 3'd2, 32'h20, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b0, 32'h0BADF00D, 4'hF, 6'd8, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
